// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and fault-decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    // Load encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings.
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Encodings with no RISC-V meaning for the given direction.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        end
        return !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                 funct3 == F3_LBU || funct3 == F3_LHU);
    endfunction

    // funct3[1:0] carries the access size for every legal encoding.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// slave = the LSU itself; master = whatever drives it (core + memory).
interface lsu_if;
    logic        i_req_valid;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misalign;
    logic        o_illegal;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_req_valid, i_we, i_funct3, i_addr, i_wdata,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_stall, o_done, o_rdata, o_misalign, o_illegal, o_bus_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );

    modport master (
        output i_req_valid, i_we, i_funct3, i_addr, i_wdata,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_stall, o_done, o_rdata, o_misalign, o_illegal, o_bus_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Bring the addressed byte down to lane 0 so extension always reads the low bits.
    assign shifted = mem_rdata >> {offset, 3'b000};

    // Store lanes: replicate the datum so it lands on every lane the enables can pick.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be         = 4'b1111;
        lane_wdata = wdata;
        if (we) begin
            case (funct3)
                F3_SB: begin
                    be         = 4'b0001 << offset;
                    lane_wdata = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be         = offset[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{wdata[15:0]}};
                end
                F3_SW:   be = 4'b1111;
                default: be = 4'b1111;
            endcase
        end
    end

    // Load extension of the selected lane.
    always_comb begin
        load_data = mem_rdata;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            F3_LW:   load_data = mem_rdata;
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: one outstanding access, alignment/illegal checks,
// bounded wait for the memory, single-cycle completion pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic  i_clk,
    input logic  i_rst,
    lsu_if.slave bus
);

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

    lsu_state_t  state, state_next;
    logic [7:0]  cnt, cnt_inc;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        misalign_q, illegal_q, bus_err_q;

    logic        req_illegal, req_misalign;
    logic        accept, capture, timeout;
    logic        in_req;
    logic [3:0]  be;
    logic [31:0] lane_wdata, load_data;

    assign req_illegal  = is_illegal(bus.i_we, bus.i_funct3);
    assign req_misalign = !req_illegal && is_misaligned(bus.i_funct3, bus.i_addr[1:0]);
    assign cnt_inc      = cnt + 8'd1;
    assign in_req       = (state == ST_REQ);

    lsu_align u_align (
        .we         (we_q),
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .mem_rdata  (bus.i_mem_rdata),
        .be         (be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode; a response in the cycle the budget runs out still wins over the timeout.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_req_valid) begin
                    accept     = 1'b1;
                    state_next = (req_illegal || req_misalign) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.i_mem_ready && (we_q || bus.i_mem_rvalid)) begin
                    capture    = !we_q;
                    state_next = ST_DONE;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    timeout    = 1'b1;
                    state_next = ST_DONE;
                end else if (bus.i_mem_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.i_mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    timeout    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latches, wait counter and completion status.
    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: these are plain flops (no memory array), so all of them are cleared by reset.
        if (!i_rst) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            we_q       <= bus.i_we;
            funct3_q   <= bus.i_funct3;
            addr_q     <= bus.i_addr;
            wdata_q    <= bus.i_wdata;
            rdata_q    <= '0;
            misalign_q <= req_misalign;
            illegal_q  <= req_illegal;
            bus_err_q  <= 1'b0;
        end else if (state == ST_REQ || state == ST_WAIT) begin
            cnt <= cnt_inc;
            if (capture) rdata_q   <= load_data;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

    // Outputs: memory side only in REQ, result side only in DONE.
    always_comb begin
        // Reset blocks acceptance, so a request seen during reset must not stall the core.
        bus.o_stall     = (state == ST_IDLE && bus.i_req_valid && i_rst) ||
                          state == ST_REQ || state == ST_WAIT;
        bus.o_done      = (state == ST_DONE);
        bus.o_rdata     = bus.o_done ? rdata_q : 32'h0;
        bus.o_misalign  = bus.o_done && misalign_q;
        bus.o_illegal   = bus.o_done && illegal_q;
        bus.o_bus_err   = bus.o_done && bus_err_q;
        bus.o_mem_req   = in_req;
        bus.o_mem_we    = in_req && we_q;
        bus.o_mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
        bus.o_mem_be    = in_req ? be : 4'h0;
        bus.o_mem_wdata = in_req ? lane_wdata : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus random
// transactions checked cycle by cycle against a transaction-level model.
module tb_load_store_unit;

    localparam int T = 16;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    lsu_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Extended load value computed from a byte view of the returned word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                               input logic [31:0] word);
        logic [7:0]         bytes [4];
        logic signed [31:0] s;
        logic [15:0]        h;
        for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
        h = {bytes[(off + 1) % 4], bytes[off]};
        case (f3)
            3'b000:  begin s = $signed(bytes[off]); return s; end
            3'b001:  begin s = $signed(h); return s; end
            3'b100:  return {24'h0, bytes[off]};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.i_req_valid  = 1'b0;
        bus.i_we         = 1'b0;
        bus.i_funct3     = 3'b000;
        bus.i_addr       = 32'h0;
        bus.i_wdata      = 32'h0;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'h0;
    endtask

    // One transaction: ready_at / rvalid_at count cycles after acceptance (1 = first).
    task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ready_at, input int rvalid_at, input logic [31:0] word);
        int          size, off, fin, done_at;
        logic        illegal, misalign, fault, bus_err, in_req;
        logic [31:0] exp_rdata, exp_wd;
        logic [3:0]  exp_be;

        off  = int'(addr[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misalign = !illegal && ((size == 2 && addr[0]) || (size == 4 && off != 0));
        fault    = illegal || misalign;

        // Lane view of a store: lane i is enabled when it falls inside the access and
        // carries byte (i mod size) of the datum; loads enable the whole word.
        exp_be = 4'b0;
        exp_wd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_be[i] = !we || (i >= off && i < off + size);
            exp_wd[8*i +: 8] = wdata[8*(i % size) +: 8];
        end

        bus_err   = 1'b0;
        exp_rdata = 32'h0;
        if (fault) begin
            done_at = 1;
        end else begin
            fin = we ? ready_at : rvalid_at;
            if (fin <= T) begin
                done_at = fin + 1;
                if (!we) exp_rdata = model_load(f3, off, word);
            end else begin
                done_at = T + 1;
                bus_err = 1'b1;
            end
        end

        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_we        = we;
        bus.i_funct3    = f3;
        bus.i_addr      = addr;
        bus.i_wdata     = wdata;
        #1;
        check({tag, ":accept_stall"}, bus.o_stall, 1'b1);
        check({tag, ":accept_memreq"}, bus.o_mem_req, 1'b0);

        for (int c = 1; c <= done_at; c++) begin
            @(negedge clk);
            bus.i_req_valid  = 1'b0;
            bus.i_we         = $urandom_range(0, 1);
            bus.i_funct3     = 3'($urandom);
            bus.i_addr       = $urandom;
            bus.i_wdata      = $urandom;
            bus.i_mem_ready  = (c == ready_at);
            bus.i_mem_rvalid = !we && (c == rvalid_at);
            bus.i_mem_rdata  = (c == rvalid_at) ? word : $urandom;
            #1;
            in_req = !fault && (c <= ready_at) && (c < done_at);
            check({tag, ":done"}, bus.o_done, c == done_at);
            check({tag, ":stall"}, bus.o_stall, c < done_at);
            check({tag, ":mem_req"}, bus.o_mem_req, in_req);
            if (in_req) begin
                check({tag, ":mem_we"}, bus.o_mem_we, we);
                check({tag, ":mem_addr"}, bus.o_mem_addr, {addr[31:2], 2'b00});
                check({tag, ":mem_be"}, bus.o_mem_be, exp_be);
                if (we) check({tag, ":mem_wdata"}, bus.o_mem_wdata, exp_wd);
            end else begin
                check({tag, ":mem_be_off"}, bus.o_mem_be, 4'h0);
            end
            if (c == done_at) begin
                check({tag, ":rdata"}, bus.o_rdata, exp_rdata);
                check({tag, ":misalign"}, bus.o_misalign, misalign);
                check({tag, ":illegal"}, bus.o_illegal, illegal);
                check({tag, ":bus_err"}, bus.o_bus_err, bus_err);
            end
        end

        @(negedge clk);
        idle_inputs();
        #1;
        check({tag, ":back_idle"}, bus.o_done, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ":stall"}, bus.o_stall, 1'b0);
        check({tag, ":done"}, bus.o_done, 1'b0);
        check({tag, ":mem_req"}, bus.o_mem_req, 1'b0);
        check({tag, ":rdata"}, bus.o_rdata, 32'h0);
        check({tag, ":mem_be"}, bus.o_mem_be, 4'h0);
    endtask

    // Release mid-cycle so the next negedge request meets the first edge out of reset.
    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Reset while a request is on the bus and while waiting for read data.
    task automatic reset_midflight();
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_we        = 1'b1;
        bus.i_funct3    = 3'b010;
        bus.i_addr      = 32'h80;
        bus.i_wdata     = 32'h5555AAAA;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        #1;
        check("rst_req:before", bus.o_mem_req, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_quiet("rst_req");
        release_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("rst_req:no_reissue", bus.o_mem_req, 1'b0);
        end

        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_we        = 1'b0;
        bus.i_funct3    = 3'b010;
        bus.i_addr      = 32'h40;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        bus.i_mem_ready = 1'b1;
        @(negedge clk);
        bus.i_mem_ready = 1'b0;
        #1;
        check("rst_wait:in_wait_stall", bus.o_stall, 1'b1);
        check("rst_wait:in_wait_memreq", bus.o_mem_req, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_quiet("rst_wait");
        bus.i_req_valid = 1'b1;
        #1;
        check("rst_wait:stall_in_reset", bus.o_stall, 1'b0);
        bus.i_req_valid = 1'b0;
        release_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = 32'hCAFEF00D;
            #1;
            check("rst_wait:late_rvalid_done", bus.o_done, 1'b0);
            check("rst_wait:late_rvalid_rdata", bus.o_rdata, 32'h0);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        int          r;
        int          v;

        rst_n = 1'b0;
        idle_inputs();
        bus.i_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        bus.i_req_valid = 1'b0;
        release_reset();

        run_txn("sw_deadbeef", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 0, 32'h0);
        run_txn("lb_neg",      1'b0, 3'b000, 32'h103, 32'h0, 1, 2, 32'h80FF_0000);
        run_txn("lbu",         1'b0, 3'b100, 32'h103, 32'h0, 1, 1, 32'h80FF_0000);
        run_txn("lh_misalign", 1'b0, 3'b001, 32'h101, 32'h0, 1, 1, 32'h0);
        run_txn("sh_upper",    1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 0, 32'h0);
        run_txn("lw_timeout",  1'b0, 3'b010, 32'h300, 32'h0, 100, 100, 32'h12345678);
        run_txn("lw_last",     1'b0, 3'b010, 32'h304, 32'h0, T, T, 32'h0BADC0DE);
        run_txn("ld_illegal",  1'b0, 3'b011, 32'h0, 32'h0, 1, 1, 32'h0);
        run_txn("st_illegal",  1'b1, 3'b100, 32'h0, 32'h0, 1, 0, 32'h0);
        run_txn("sb_lane1",    1'b1, 3'b000, 32'h401, 32'h000000A5, 2, 0, 32'h0);
        run_txn("lhu_hi",      1'b0, 3'b101, 32'h502, 32'h0, 2, 5, 32'h8001_7FFF);

        reset_midflight();
        run_txn("after_reset", 1'b0, 3'b001, 32'h602, 32'h0, 1, 3, 32'hF00D_1234);

        for (int n = 0; n < 60; n++) begin
            we = $urandom_range(0, 1);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                 (we ? 3'($urandom_range(0, 2)) : 3'(3'b010 ^ 3'($urandom_range(0, 1) * 4)
                                                     ^ 3'($urandom_range(0, 2))));
            r  = $urandom_range(1, T + 3);
            v  = r + $urandom_range(0, 4);
            run_txn("rand", we, f3, $urandom, $urandom, r, v, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait above never completes.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
